// File: rtl/mux_reg_arbiter_if.sv
// Handshake bundle between two producers, the mux/register arbiter and one consumer.
// The slave modport is the arbiter's view. The master modport is the surrounding logic's view.
interface mux_reg_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic             sel;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, sel
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, sel
  );
endinterface

// File: rtl/mux_reg_arbiter.sv
// Round-robin 2:1 mux feeding one output register, one cycle of latency; readies drop while full and stalled.
// Defining MUX_ARB_BURST_EN lets the last winner keep ties for up to BURST consecutive beats.
module mux_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux_reg_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_src;
  logic             r_last;
  logic             w_valid;
  logic             w_load_en;
  logic             w_tie;
  logic             w_keep;
  logic             w_sel;
  logic             w_accept;

  if (BURST < 1 || BURST > 15) begin : g_burst_range
    $error("mux_reg_arbiter: BURST must be within 1..15");
  end

  assign w_valid   = (r_state == FULL);
  assign w_load_en = !w_valid || bus.out_ready;
  assign w_tie     = bus.req0_valid && bus.req1_valid;

`ifdef MUX_ARB_BURST_EN
  localparam logic [3:0] BURST_L = 4'(BURST);
  logic [3:0] r_cnt;

  // A zero count means no burst is running, so a tie falls back to alternation.
  assign w_keep = (r_cnt != 4'd0) && (r_cnt < BURST_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_load_en) begin
      if (!w_accept)
        r_cnt <= 4'd0;
      else if (w_sel != r_last)
        r_cnt <= 4'd1;
      else if (r_cnt != 4'hF)
        r_cnt <= r_cnt + 4'd1;
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  always_comb begin
    w_sel = r_last;
    if (w_tie)
      w_sel = w_keep ? r_last : !r_last;
    else if (bus.req0_valid)
      w_sel = 1'b0;
    else if (bus.req1_valid)
      w_sel = 1'b1;
  end

  assign w_accept = w_load_en && !rst && (w_sel ? bus.req1_valid : bus.req0_valid);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)
      w_state_nxt = FULL;
    else if (w_valid && bus.out_ready)
      w_state_nxt = EMPTY;
  end

  always_comb begin
    bus.out_valid  = w_valid;
    bus.sel        = w_sel;
    bus.req0_ready = w_accept && !w_sel;
    bus.req1_ready = w_accept && w_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= 1'b0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_data <= w_sel ? bus.req1_data : bus.req0_data;
      r_src  <= w_sel;
      r_last <= w_sel;
    end
  end

  assign bus.out_data = r_data;
  assign bus.out_src  = r_src;
endmodule

// File: tb/tb_mux_reg_arbiter.sv
// Directed bench: stimulus pushes expected {src,data} beats, a monitor pops them at each output handshake.
module tb_mux_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [8:0] exp_q[$];

  mux_reg_arbiter_if #(.WIDTH(8)) bus ();

  mux_reg_arbiter #(.WIDTH(8), .BURST(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // One clock of stimulus; e0/e1 are the hand-computed expected readies.
  task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                     input logic ordy, input logic e0, input logic e1, input string nm);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.out_ready  = ordy;
    @(negedge clk);
    chk({nm, "_rdy0"}, 32'(bus.req0_ready), 32'(e0));
    chk({nm, "_rdy1"}, 32'(bus.req1_ready), 32'(e1));
    if (e0) exp_q.push_back({1'b0, d0});
    if (e1) exp_q.push_back({1'b1, d1});
    @(posedge clk);
    #1;
  endtask

  task automatic rcyc();
    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hE0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hE1;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1", 32'(bus.req1_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_beat: got src=%0d data=%0h required no beat", bus.out_src, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 32'({bus.out_src, bus.out_data}), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    logic [6:0] g;
    logic       rel1;
    logic       tie2;

`ifdef MUX_ARB_BURST_EN
    g    = 7'b0111000;
    rel1 = 1'b1;
    tie2 = 1'b0;
`else
    g    = 7'b0101010;
    rel1 = 1'b0;
    tie2 = 1'b1;
`endif

    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.out_ready  = 1'b0;

    rcyc();
    rcyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_src",   32'(bus.out_src),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      cyc(1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1, !g[i], g[i], "contend");

    cyc(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "single");
    cyc(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "single");
    cyc(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "single");
    chk("single_last_data", 32'(bus.out_data), 32'h33);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "idle");
    chk("idle_sel_holds", 32'(bus.sel), 32'd0);

    cyc(1'b0, 8'h00, 1'b1, 8'h5C, 1'b1, 1'b0, 1'b1, "bp_load");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, "bp_stall");
      chk("bp_out_data",  32'(bus.out_data),  32'h5C);
      chk("bp_out_src",   32'(bus.out_src),   32'd1);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    cyc(1'b1, 8'h77, 1'b1, 8'h88, 1'b1, !rel1, rel1, "bp_release");

    cyc(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "dl_fill");
    cyc(1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, "dl_swap");
    chk("dl_out_valid", 32'(bus.out_valid), 32'd1);
    chk("dl_out_data",  32'(bus.out_data),  32'h02);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "dl_hold");
    chk("dl_hold_src", 32'(bus.out_src), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "dl_drain");

    cyc(1'b1, 8'h3A, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, "pre_rst");
    rcyc();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data",  32'(bus.out_data),  32'd0);
    rst = 1'b0;
    cyc(1'b1, 8'hC0, 1'b1, 8'hD1, 1'b1, 1'b1, 1'b0, "post_rst_tie");
    cyc(1'b1, 8'hC2, 1'b1, 8'hD3, 1'b1, !tie2, tie2, "post_rst_tie2");

    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "final_drain");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
